// File: rtl/adder.sv
// adder: two-stage pipelined unsigned adder.
// Stage 1 captures both operands, stage 2 captures their sum. A result
// therefore appears on Y one edge after the operands are registered,
// i.e. two edges after they are first presented. The sum wraps modulo
// 2^DATA_WIDTH; the carry out of the MSB is dropped on purpose because
// the block has no carry or overflow output.
module adder #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] A0,
    input  logic [DATA_WIDTH-1:0] A1,
    output logic [DATA_WIDTH-1:0] Y
);

    logic [DATA_WIDTH-1:0] r_aQ;
    logic [DATA_WIDTH-1:0] r_bQ;
    logic [DATA_WIDTH-1:0] r_y;
    logic [DATA_WIDTH-1:0] w_sum;

    // Stage-2 adder: same-width result, so the MSB carry falls off naturally
    assign w_sum = r_aQ + r_bQ;

    // Operand stage: reset discards whatever pair is in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aQ <= '0;
            r_bQ <= '0;
        end else begin
            r_aQ <= A0;
            r_bQ <= A1;
        end
    end

    // Result stage: Y comes only from this flop, never straight from inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_sum;
        end
    end

    assign Y = r_y;

endmodule

// File: tb/tb_adder.sv
// tb_adder: self-checking bench for the pipelined adder.
// Inputs are driven on the falling edge and Y is sampled on the following
// falling edge, so each call to applyStimulus advances exactly one clock.
// The reference model keeps a history of every rising edge (reset level
// and the operand pair present) and derives the expected Y from the
// rule "Y after edge e is the wrapped sum of the pair seen at edge e-1,
// unless either edge was a reset edge, in which case it is zero".
module tb_adder;

    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] a0;
        logic [DW-1:0] a1;
        logic [DW-1:0] y;
    } vec_t;

    typedef struct {
        logic          rstn;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } edge_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] A0;
    logic [DW-1:0] A1;
    logic [DW-1:0] Y;

    int testsRun    = 0;
    int testsFailed = 0;

    edge_t history[$];

    adder #(.DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A0   (A0),
        .A1   (A1),
        .Y    (Y)
    );

    // 10 ns clock period
    always #5 clk = ~clk;

    // Expected Y right now, from the recorded edge history
    function automatic logic [DW-1:0] modelY();
        int    n;
        edge_t cur;
        edge_t prev;
        int    total;
        n = history.size();
        if (n == 0) return '0;
        cur = history[n-1];
        if (!cur.rstn) return '0;
        if (n < 2) return '0;
        prev = history[n-2];
        if (!prev.rstn) return '0;
        total = (int'(prev.a) + int'(prev.b)) % (1 << DW);
        return DW'(total);
    endfunction

    // Compare Y against a required value
    task automatic compareY(input string name, input logic [DW-1:0] want);
        testsRun++;
        if (Y !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: Y=0x%04h required 0x%04h at %0t", name, Y, want, $time);
        end
    endtask

    // Compare Y against the reference model
    task automatic checkOutput(input string name);
        compareY(name, modelY());
    endtask

    // Drive one pair (called at a negedge), run one edge, land on next negedge
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic rstn, input string name);
        edge_t e;
        A0    = a;
        A1    = b;
        rst_n = rstn;
        @(posedge clk);
        e.rstn = rstn;
        e.a    = a;
        e.b    = b;
        history.push_back(e);
        @(negedge clk);
        checkOutput(name);
    endtask

    vec_t single[4];
    vec_t stream[9];

    initial begin
        single[0] = '{16'h0001, 16'h0002, 16'h0003};
        single[1] = '{16'hFFFF, 16'h0001, 16'h0000};
        single[2] = '{16'h8000, 16'h8000, 16'h0000};
        single[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFE};

        stream[0] = '{16'h0000, 16'h0000, 16'h0000};
        stream[1] = '{16'h1234, 16'h4321, 16'h5555};
        stream[2] = '{16'h7FFF, 16'h0001, 16'h8000};
        stream[3] = '{16'hAAAA, 16'h5555, 16'hFFFF};
        stream[4] = '{16'hFFFF, 16'h0001, 16'h0000};
        stream[5] = '{16'h8000, 16'h8000, 16'h0000};
        stream[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFE};
        stream[7] = '{16'h0001, 16'h0002, 16'h0003};
        stream[8] = '{16'h00FF, 16'h0F01, 16'h1000};

        rst_n = 1'b0;
        A0    = 16'h1234;
        A1    = 16'h1111;

        // Reset for one edge with non-zero operands present
        applyStimulus(16'h1234, 16'h1111, 1'b0, "resetModel");
        compareY("resetY", 16'h0000);
        applyStimulus(16'h1234, 16'h1111, 1'b1, "releaseModel");
        compareY("postReleaseY", 16'h0000);
        applyStimulus(16'h0000, 16'h0000, 1'b1, "firstSumModel");
        compareY("firstSumY", 16'h2345);

        // Isolated pairs: Y checked two edges after the pair is applied
        for (int i = 0; i < 4; i++) begin
            applyStimulus(single[i].a0, single[i].a1, 1'b1, "singleModel");
            applyStimulus(16'h0000, 16'h0000, 1'b1, "singleFlushModel");
            compareY($sformatf("single%0d", i), single[i].y);
        end

        // Back-to-back stream: one result per clock, no bubbles
        for (int i = 0; i < 10; i++) begin
            if (i < 9) applyStimulus(stream[i].a0, stream[i].a1, 1'b1, "streamModel");
            else       applyStimulus(16'h0000, 16'h0000, 1'b1, "streamModel");
            if (i >= 1) compareY($sformatf("stream%0d", i - 1), stream[i-1].y);
        end
        applyStimulus(16'h0000, 16'h0000, 1'b1, "streamFlushModel");

        // Mid-stream reset: pair sampled on the reset edge is lost
        applyStimulus(16'h1000, 16'h0234, 1'b1, "midP1");
        applyStimulus(16'h2222, 16'h1111, 1'b1, "midP2");
        compareY("midBeforeReset", 16'h1234);
        applyStimulus(16'h4000, 16'h0005, 1'b0, "midP3Reset");
        compareY("midResetY", 16'h0000);
        applyStimulus(16'h0100, 16'h0200, 1'b1, "midP4");
        compareY("midLostPair", 16'h0000);
        applyStimulus(16'h0F0F, 16'hF0F0, 1'b1, "midP5");
        compareY("midPostReset1", 16'h0300);
        applyStimulus(16'h0000, 16'h0000, 1'b1, "midFlush");
        compareY("midPostReset2", 16'hFFFF);

        // Random operands every cycle, checked against the model
        for (int i = 0; i < 300; i++) begin
            applyStimulus(DW'($urandom), DW'($urandom), 1'b1, "random");
        end

        // Random operands with occasional reset edges
        for (int i = 0; i < 200; i++) begin
            applyStimulus(DW'($urandom), DW'($urandom),
                          ($urandom_range(0, 15) != 0), "randomReset");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
